// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: RV32 decode into operands, main/skid buffered handshake
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            inFlush,
    input  logic            inValid,
    output logic            inReady,
    input  logic [6:0]      inOpcode,
    input  logic [2:0]      inFunct3,
    input  logic [6:0]      inFunct7,
    input  logic [XLEN-1:0] inRs1,
    input  logic [XLEN-1:0] inRs2,
    input  logic [XLEN-1:0] inImm,
    input  logic [XLEN-1:0] inPC,
    input  logic [4:0]      inRd,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outALUa,
    output logic [XLEN-1:0] outALUb,
    output logic [3:0]      outALUSel,
    output logic [4:0]      outRd,
    output logic            outWe,
    output logic            outIllegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_AND  = 4'd1;
    localparam logic [3:0] SEL_OR   = 4'd2;
    localparam logic [3:0] SEL_XOR  = 4'd3;
    localparam logic [3:0] SEL_SRL  = 4'd4;
    localparam logic [3:0] SEL_SRA  = 4'd5;
    localparam logic [3:0] SEL_SLL  = 4'd6;
    localparam logic [3:0] SEL_SLT  = 4'd7;
    localparam logic [3:0] SEL_MULL = 4'd10;
    localparam logic [3:0] SEL_MULH = 4'd11;
    localparam logic [3:0] SEL_SUB  = 4'd12;
    localparam logic [3:0] SEL_PASSB = 4'd13;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      sel;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } payload_t;

    payload_t dec;
    payload_t main_q;
    payload_t skid_q;
    logic     main_valid;
    logic     skid_valid;
    logic     legal;
    logic     xfer_in;
    logic     xfer_out;

    // Shared funct3 map for the base OP and OP-IMM groups
    function automatic logic [3:0] base_sel(input logic [2:0] f3);
        case (f3)
            3'b000:  base_sel = SEL_ADD;
            3'b001:  base_sel = SEL_SLL;
            3'b010:  base_sel = SEL_SLT;
            3'b011:  base_sel = SEL_SLT;
            3'b100:  base_sel = SEL_XOR;
            3'b101:  base_sel = SEL_SRL;
            3'b110:  base_sel = SEL_OR;
            default: base_sel = SEL_AND;
        endcase
    endfunction

    always_comb begin
        dec    = '0;
        dec.rd = inRd;
        legal  = 1'b1;
        case (inOpcode)
            OPC_OP: begin
                dec.a  = inRs1;
                dec.b  = inRs2;
                dec.we = 1'b1;
                case (inFunct7)
                    F7_BASE: dec.sel = base_sel(inFunct3);
                    F7_ALT: begin
                        if (inFunct3 == 3'b000)      dec.sel = SEL_SUB;
                        else if (inFunct3 == 3'b101) dec.sel = SEL_SRA;
                        else                         legal = 1'b0;
                    end
                    F7_MUL: begin
                        if (inFunct3 == 3'b000)      dec.sel = SEL_MULL;
                        else if (inFunct3 == 3'b011) dec.sel = SEL_MULH;
                        else                         legal = 1'b0;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                dec.a   = inRs1;
                dec.b   = inImm;
                dec.we  = 1'b1;
                dec.sel = base_sel(inFunct3);
                if (inFunct3 == 3'b001 && inFunct7 != F7_BASE) legal = 1'b0;
                if (inFunct3 == 3'b101) begin
                    if (inFunct7 == F7_ALT)       dec.sel = SEL_SRA;
                    else if (inFunct7 != F7_BASE) legal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec.b   = inImm;
                dec.sel = SEL_PASSB;
                dec.we  = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a  = inPC;
                dec.b  = inImm;
                dec.we = 1'b1;
            end
            OPC_LOAD, OPC_STORE: begin
                dec.a  = inRs1;
                dec.b  = inImm;
                dec.we = (inOpcode == OPC_LOAD);
            end
            default: legal = 1'b0;
        endcase
        // Illegal payloads still flow through the pipe, just with neutral operands
        if (!legal) begin
            dec.a       = '0;
            dec.b       = '0;
            dec.sel     = SEL_ADD;
            dec.we      = 1'b0;
            dec.illegal = 1'b1;
        end
    end

    assign inReady  = !skid_valid;
    assign xfer_in  = inValid && inReady;
    assign xfer_out = main_valid && outReady;

    always_ff @(posedge clk) begin
        if (!rstN || inFlush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (!main_valid || xfer_out) begin
            // Skid always drains first so ordering is preserved
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (xfer_in) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (xfer_in) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign outValid   = main_valid;
    assign outALUa    = main_q.a;
    assign outALUb    = main_q.b;
    assign outALUSel  = main_q.sel;
    assign outRd      = main_q.rd;
    assign outWe      = main_q.we;
    assign outIllegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - bench for alu_issue_stage: decode table, hand sequences, random vs queue model
module tb_alu_issue_stage;

    logic        clk;
    logic        rstN;
    logic        inFlush;
    logic        inValid;
    logic        inReady;
    logic [6:0]  inOpcode;
    logic [2:0]  inFunct3;
    logic [6:0]  inFunct7;
    logic [31:0] inRs1, inRs2, inImm, inPC;
    logic [4:0]  inRd;
    logic        outValid;
    logic        outReady;
    logic [31:0] outALUa, outALUb;
    logic [3:0]  outALUSel;
    logic [4:0]  outRd;
    logic        outWe;
    logic        outIllegal;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rstN(rstN), .inFlush(inFlush),
        .inValid(inValid), .inReady(inReady),
        .inOpcode(inOpcode), .inFunct3(inFunct3), .inFunct7(inFunct7),
        .inRs1(inRs1), .inRs2(inRs2), .inImm(inImm), .inPC(inPC), .inRd(inRd),
        .outValid(outValid), .outReady(outReady),
        .outALUa(outALUa), .outALUb(outALUb), .outALUSel(outALUSel),
        .outRd(outRd), .outWe(outWe), .outIllegal(outIllegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } pl_t;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  esel;
        logic        ewe;
        logic        eill;
    } vec_t;

    localparam logic [3:0] F3MAP [8] = '{4'd0, 4'd6, 4'd7, 4'd7, 4'd3, 4'd4, 4'd2, 4'd1};
    localparam logic [31:0] RS1 = 32'h0000_0005;
    localparam logic [31:0] RS2 = 32'h0000_0007;
    localparam logic [31:0] IMM = 32'h1234_5000;
    localparam logic [31:0] PC  = 32'h0000_1000;

    int  n_cmp = 0;
    int  n_bad = 0;
    pl_t q[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-group rules
    function automatic pl_t ref_dec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd);
        pl_t p;
        bit  ok;
        p = '0;
        ok = 0;
        if (opc == 7'b0110011) begin
            p.a = rs1; p.b = rs2; p.we = 1;
            if (f7 == 7'h00) begin ok = 1; p.sel = F3MAP[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; p.sel = 4'd12; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; p.sel = 4'd5; end
            else if (f7 == 7'h01 && f3 == 3'd0) begin ok = 1; p.sel = 4'd10; end
            else if (f7 == 7'h01 && f3 == 3'd3) begin ok = 1; p.sel = 4'd11; end
        end else if (opc == 7'b0010011) begin
            p.a = rs1; p.b = imm; p.we = 1;
            if (f3 == 3'd1)      begin ok = (f7 == 7'h00); p.sel = 4'd6; end
            else if (f3 == 3'd5) begin ok = (f7 == 7'h00 || f7 == 7'h20); p.sel = (f7 == 7'h20) ? 4'd5 : 4'd4; end
            else                 begin ok = 1; p.sel = F3MAP[f3]; end
        end else if (opc == 7'b0110111) begin ok = 1; p.a = 0;   p.b = imm; p.sel = 4'd13; p.we = 1; end
        else if (opc == 7'b0010111)     begin ok = 1; p.a = pc;  p.b = imm; p.sel = 4'd0;  p.we = 1; end
        else if (opc == 7'b0000011)     begin ok = 1; p.a = rs1; p.b = imm; p.sel = 4'd0;  p.we = 1; end
        else if (opc == 7'b0100011)     begin ok = 1; p.a = rs1; p.b = imm; p.sel = 4'd0;  p.we = 0; end
        if (!ok) begin p = '0; p.ill = 1; end
        p.rd = rd;
        return p;
    endfunction

    // One clock: check state against the model, advance the model, then step past the edge
    task automatic step();
        int v;
        @(negedge clk);
        v = q.size();
        chk("out_valid", {31'b0, outValid}, {31'b0, v > 0});
        chk("in_ready", {31'b0, inReady}, {31'b0, v < 2});
        if (v > 0) begin
            chk("model_a", outALUa, q[0].a);
            chk("model_b", outALUb, q[0].b);
            chk("model_sel", {28'b0, outALUSel}, {28'b0, q[0].sel});
            chk("model_rd", {27'b0, outRd}, {27'b0, q[0].rd});
            chk("model_we", {31'b0, outWe}, {31'b0, q[0].we});
            chk("model_ill", {31'b0, outIllegal}, {31'b0, q[0].ill});
        end
        if (!rstN || inFlush) begin
            q.delete();
        end else begin
            if (v > 0 && outReady) void'(q.pop_front());
            if (inValid && v < 2)
                q.push_back(ref_dec(inOpcode, inFunct3, inFunct7, inRs1, inRs2, inImm, inPC, inRd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd);
        inValid = 1; inOpcode = opc; inFunct3 = f3; inFunct7 = f7; inRd = rd;
        inRs1 = RS1; inRs2 = RS2; inImm = IMM; inPC = PC;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_valid"}, {31'b0, outValid}, 32'd0);
        chk({nm, "_ready"}, {31'b0, inReady}, 32'd1);
        chk({nm, "_a"}, outALUa, 32'd0);
        chk({nm, "_b"}, outALUb, 32'd0);
        chk({nm, "_sel"}, {28'b0, outALUSel}, 32'd0);
        chk({nm, "_rd"}, {27'b0, outRd}, 32'd0);
        chk({nm, "_we"}, {31'b0, outWe}, 32'd0);
        chk({nm, "_ill"}, {31'b0, outIllegal}, 32'd0);
    endtask

    initial begin
        logic [6:0] opcs [8];
        logic [6:0] f7s [4];
        opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                 7'b0000011, 7'b0100011, 7'b1111111, 7'b0110011};
        f7s  = '{7'h00, 7'h20, 7'h01, 7'h7f};

        tbl.push_back('{7'b0110011, 3'd0, 7'h00, RS1, RS2, 4'd0,  1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd5, 7'h20, RS1, RS2, 4'd5,  1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd3, 7'h01, RS1, RS2, 4'd11, 1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd0, 7'h01, RS1, RS2, 4'd10, 1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd0, 7'h20, RS1, RS2, 4'd12, 1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd1, 7'h00, RS1, RS2, 4'd6,  1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd2, 7'h00, RS1, RS2, 4'd7,  1'b1, 1'b0});
        tbl.push_back('{7'b0110011, 3'd1, 7'h01, 0,   0,   4'd0,  1'b0, 1'b1});
        tbl.push_back('{7'b0010011, 3'd5, 7'h20, RS1, IMM, 4'd5,  1'b1, 1'b0});
        tbl.push_back('{7'b0010011, 3'd7, 7'h55, RS1, IMM, 4'd1,  1'b1, 1'b0});
        tbl.push_back('{7'b0010011, 3'd1, 7'h20, 0,   0,   4'd0,  1'b0, 1'b1});
        tbl.push_back('{7'b0110111, 3'd0, 7'h00, 0,   IMM, 4'd13, 1'b1, 1'b0});
        tbl.push_back('{7'b0010111, 3'd0, 7'h00, PC,  IMM, 4'd0,  1'b1, 1'b0});
        tbl.push_back('{7'b0000011, 3'd2, 7'h00, RS1, IMM, 4'd0,  1'b1, 1'b0});
        tbl.push_back('{7'b0100011, 3'd2, 7'h00, RS1, IMM, 4'd0,  1'b0, 1'b0});
        tbl.push_back('{7'b1111111, 3'd0, 7'h00, 0,   0,   4'd0,  1'b0, 1'b1});

        rstN = 0; inFlush = 0; inValid = 0; outReady = 1;
        inOpcode = 0; inFunct3 = 0; inFunct7 = 0;
        inRs1 = 0; inRs2 = 0; inImm = 0; inPC = 0; inRd = 0;
        #1;
        step();
        step();
        chk_all_zero("reset");
        rstN = 1;

        // Decode table: one beat each, visible the cycle after acceptance
        foreach (tbl[i]) begin
            drive(tbl[i].opc, tbl[i].f3, tbl[i].f7, 5'(i + 1));
            step();
            inValid = 0;
            chk($sformatf("tbl%0d_valid", i), {31'b0, outValid}, 32'd1);
            chk($sformatf("tbl%0d_a", i), outALUa, tbl[i].ea);
            chk($sformatf("tbl%0d_b", i), outALUb, tbl[i].eb);
            chk($sformatf("tbl%0d_sel", i), {28'b0, outALUSel}, {28'b0, tbl[i].esel});
            chk($sformatf("tbl%0d_we", i), {31'b0, outWe}, {31'b0, tbl[i].ewe});
            chk($sformatf("tbl%0d_ill", i), {31'b0, outIllegal}, {31'b0, tbl[i].eill});
            chk($sformatf("tbl%0d_rd", i), {27'b0, outRd}, 32'(i + 1));
        end
        step();

        // Back-to-back beats into a stalled output
        outReady = 0;
        drive(7'b0110011, 3'd0, 7'h00, 5'd1); step();
        drive(7'b0110011, 3'd4, 7'h00, 5'd2); step();
        chk("stall_in_ready", {31'b0, inReady}, 32'd0);
        drive(7'b0110011, 3'd6, 7'h00, 5'd3); step();
        chk("stall_hold_rd", {27'b0, outRd}, 32'd1);
        chk("stall_hold_sel", {28'b0, outALUSel}, 32'd0);
        outReady = 1; step();
        chk("drain_rd2", {27'b0, outRd}, 32'd2);
        chk("drain_ready", {31'b0, inReady}, 32'd1);
        step();
        inValid = 0;
        chk("drain_rd3", {27'b0, outRd}, 32'd3);
        chk("drain_sel3", {28'b0, outALUSel}, 32'd2);
        step();
        chk("drain_empty", {31'b0, outValid}, 32'd0);

        // Flush with both entries full
        outReady = 0;
        drive(7'b0110011, 3'd0, 7'h00, 5'd4); step();
        drive(7'b0110011, 3'd0, 7'h00, 5'd5); step();
        inFlush = 1; step();
        inFlush = 0; inValid = 0;
        chk("flush_valid", {31'b0, outValid}, 32'd0);
        chk("flush_ready", {31'b0, inReady}, 32'd1);

        // Reset and flush together with both entries full
        drive(7'b0110011, 3'd0, 7'h00, 5'd6); step();
        drive(7'b0110011, 3'd0, 7'h00, 5'd7); step();
        rstN = 0; inFlush = 1; step();
        rstN = 1; inFlush = 0; inValid = 0;
        chk_all_zero("rstflush");
        outReady = 1;

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            inValid  = ($urandom % 4) != 0;
            outReady = ($urandom % 3) != 0;
            inFlush  = ($urandom % 60) == 0;
            rstN     = ($urandom % 120) != 0;
            inOpcode = opcs[$urandom % 8];
            inFunct3 = 3'($urandom);
            inFunct7 = f7s[$urandom % 4];
            inRs1 = $urandom; inRs2 = $urandom; inImm = $urandom; inPC = $urandom;
            inRd  = 5'($urandom);
            step();
        end
        rstN = 1; inFlush = 0; inValid = 0; outReady = 1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstN  input  1  reset, synchronous, active-low.
REQ-004 inFlush  input  1  synchronous pipeline flush.
REQ-005 inValid  input  1  upstream payload valid.
REQ-006 inReady  output  1  stage can accept this cycle.
REQ-007 inOpcode  input  7  instruction bits [6:0].
REQ-008 inFunct3  input  3  instruction bits [14:12].
REQ-009 inFunct7  input  7  instruction bits [31:25].
REQ-010 inRs1, inRs2, inImm, inPC  input  32 each  register operands, sign-extended immediate, instruction address.
REQ-011 inRd  input  5  destination register.
REQ-012 outValid  output  1  ALU payload valid.
REQ-013 outReady  input  1  downstream accepts.
REQ-014 outALUa, outALUb  output  32 each  ALU operands.
REQ-015 outALUSel  output  4  ALU operation code.
REQ-016 outRd  output  5; outWe  output  1  writeback enable; outIllegal  output  1  decode failed.

Function
REQ-017 Transfer in = inValid & inReady; transfer out = outValid & outReady.
REQ-018 Two storage entries: output register (main) and skid register; inReady SHALL equal NOT skid-occupied.
REQ-019 Latency: payload accepted in cycle N SHALL appear on outputs in cycle N+1; sustained throughput one per cycle while outReady=1.
REQ-020 Main empty or transfer out: main loads skid if occupied (skid clears, and new input, if any, goes to skid), else loads input if transfer in, else main empties.
REQ-021 Main full, no transfer out, transfer in: input captured into skid; inReady deasserts next cycle.
REQ-022 Output payload SHALL be stable while outValid=1 and outReady=0; order SHALL be preserved.
REQ-023 Decode SHALL be performed on input side before storage; ALUSel codes: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 SRL, 5 SRA, 6 SLL, 7 SLT, 10 MUL-low, 11 MUL-high, 12 SUB, 13 pass-B.
REQ-024 OP (0110011), funct7=0000000: funct3 000 ADD, 001 SLL, 010/011 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND; funct7=0100000: 000 SUB, 101 SRA; A=rs1, B=rs2, We=1.
REQ-025 OP with funct7=0000001: funct3 000 -> 10, 011 -> 11; other funct3 illegal.
REQ-026 OP-IMM (0010011): same funct3 map with B=imm, no SUB; 001 requires funct7=0000000; 101 selects SRL/SRA by funct7 0000000/0100000; else illegal.
REQ-027 LUI (0110111): A=0, B=imm, Sel=13, We=1; AUIPC (0010111): A=PC, B=imm, Sel=0, We=1.
REQ-028 LOAD (0000011): A=rs1, B=imm, Sel=0, We=1; STORE (0100011): same with We=0.
REQ-029 Any other opcode/funct combination: outIllegal=1, A=B=0, Sel=0, We=0, still handshaked as a normal payload.
REQ-030 outRd SHALL be inRd unchanged; arithmetic none inside this stage.
REQ-031 inFlush=1: both entries cleared next cycle, input offered that cycle dropped, inReady=1 next cycle.

Reset
REQ-032 rstN=0 at a clock edge clears both entries: outValid=0, inReady=1, all payload outputs 0; input offered that cycle is dropped.
REQ-033 Reset SHALL take priority over inFlush and over any handshake, including mid-stall.

Verification
REQ-034 Reset then inValid=1, OP ADD, rs1=5, rs2=7, outReady=1 -> next cycle outValid=1, A=5, B=7, Sel=0, We=1.
REQ-035 OP funct7=0100000 funct3=101 -> Sel=5; OP-IMM funct3=101 funct7=0100000 -> Sel=5, B=imm; OP funct7=0000001 funct3=011 -> Sel=11.
REQ-036 outReady=0, three back-to-back inValid beats -> first in main, second in skid, inReady=0, third held upstream; outReady=1 then drains in order, no loss or duplicate.
REQ-037 LUI imm=0x12345000 -> A=0, B=0x12345000, Sel=13; STORE -> We=0; opcode 1111111 -> outIllegal=1, We=0.
REQ-038 Both entries full, inFlush=1 -> next cycle outValid=0, inReady=1; repeat with rstN=0 and inFlush=1 together -> all outputs 0.
